// File: rtl/seq_shifter16.sv
// Sequential 16-bit shifter/rotator: one 1-bit step per clock, B steps per request.
// state | meaning
// IDLE  | waiting for start; out/co hold the last result
// SHIFT | one 1-bit shift/rotate per edge, cnt counts down to 1
// DONE  | single-cycle done pulse, out/co valid
module seq_shifter16 (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] A,
  input  logic [3:0]  B,
  input  logic        dir,
  input  logic        s,
  input  logic        rot,
  output logic [15:0] out,
  output logic        co,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [3:0]  cnt;
  logic        dir_q;
  logic        s_q;
  logic        rot_q;
  logic [15:0] step_out;
  logic        step_co;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = (B == 4'd0) ? DONE : SHIFT;
      SHIFT:   if (cnt == 4'd1) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
    done = (state == DONE);
  end

  // One 1-bit step in the latched mode; rotate overrides the right-shift fill.
  always_comb begin
    step_out = out;
    step_co  = co;
    if (!dir_q) begin
      step_out = {out[14:0], rot_q ? out[15] : 1'b0};
      step_co  = out[15];
    end else begin
      step_out = {rot_q ? out[0] : (s_q ? out[15] : 1'b0), out[15:1]};
      step_co  = out[0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out   <= 16'h0000;
      co    <= 1'b0;
      cnt   <= 4'd0;
      dir_q <= 1'b0;
      s_q   <= 1'b0;
      rot_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            out   <= A;
            cnt   <= B;
            dir_q <= dir;
            s_q   <= s;
            rot_q <= rot;
            co    <= 1'b0;
          end
        end
        SHIFT: begin
          out <= step_out;
          co  <= step_co;
          cnt <= cnt - 4'd1;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_shifter16.sv
// Scoreboarded directed bench for seq_shifter16: result, carry, latency, busy and reset behaviour.
module tb_seq_shifter16;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] A;
  logic [3:0]  B;
  logic        dir;
  logic        s;
  logic        rot;
  logic [15:0] out;
  logic        co;
  logic        busy;
  logic        done;

  int errors = 0;
  int checks = 0;
  logic [16:0] exp_q[$];

  seq_shifter16 dut (
    .clk(clk), .rst(rst), .start(start), .A(A), .B(B), .dir(dir), .s(s), .rot(rot),
    .out(out), .co(co), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: whole-word shift/rotate of a by b, packed as {out, co}.
  function automatic logic [16:0] model(input logic [15:0] a, input logic [3:0] b,
                                        input logic d, input logic ss, input logic r);
    logic [15:0] o;
    logic        c;
    logic [16:0] t;
    if (r) begin
      if (!d) o = (a << b) | (a >> (16 - int'(b)));
      else    o = (a >> b) | (a << (16 - int'(b)));
      c = (b == 4'd0) ? 1'b0 : (d ? o[15] : o[0]);
    end else if (!d) begin
      t = {1'b0, a} << b;
      o = t[15:0];
      c = t[16];
    end else begin
      t = {a, 1'b0};
      if (ss) t = $signed(t) >>> b;
      else    t = t >> b;
      o = t[16:1];
      c = t[0];
    end
    return {o, c};
  endfunction

  // Issue one request; poke keeps start high with fresh A for the whole busy period.
  task automatic do_op(input logic [15:0] a, input logic [3:0] b, input logic d,
                       input logic ss, input logic r, input logic poke);
    int          cycles;
    int          busy_n;
    logic [16:0] exp;
    @(negedge clk);
    A = a; B = b; dir = d; s = ss; rot = r; start = 1'b1;
    exp_q.push_back(model(a, b, d, ss, r));
    @(negedge clk);
    start = poke;
    A = ~a; B = ~b; dir = ~d; s = ~ss; rot = ~r;
    cycles = 0;
    busy_n = 0;
    forever begin
      cycles++;
      if (busy) busy_n++;
      if (done || cycles >= 40) break;
      @(negedge clk);
      if (poke) A = 16'($urandom);
    end
    chk("latency", cycles, int'(b) + 1);
    chk("busy_cycles", busy_n, int'(b) + 1);
    exp = exp_q.pop_front();
    chk("out", out, exp[16:1]);
    chk("co", co, exp[0]);
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    chk("done_pulse", done, 1'b0);
    chk("idle_busy", busy, 1'b0);
    chk("out_hold", {out, co}, exp);
  endtask

  initial begin
    int seen;
    rst = 1'b1; start = 1'b0; A = 16'h0; B = 4'h0; dir = 1'b0; s = 1'b0; rot = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_out", out, 16'h0000);
    chk("rst_co", co, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    // start is ignored while reset is held
    start = 1'b1; A = 16'h1234; B = 4'd2;
    @(negedge clk);
    chk("rst_prio_busy", busy, 1'b0);
    start = 1'b0;
    rst = 1'b0;

    do_op(16'h0001, 4'd4,  1'b0, 1'b0, 1'b0, 1'b0);
    do_op(16'h8000, 4'd3,  1'b1, 1'b1, 1'b0, 1'b0);
    do_op(16'h8000, 4'd3,  1'b1, 1'b0, 1'b0, 1'b0);
    do_op(16'h8001, 4'd1,  1'b1, 1'b0, 1'b1, 1'b0);
    do_op(16'hFFFF, 4'd15, 1'b0, 1'b0, 1'b0, 1'b0);
    do_op(16'hBEEF, 4'd0,  1'b0, 1'b0, 1'b0, 1'b1);
    do_op(16'hA5C3, 4'd15, 1'b1, 1'b1, 1'b0, 1'b0);
    do_op(16'h1234, 4'd5,  1'b0, 1'b1, 1'b1, 1'b1);
    do_op(16'h00F1, 4'd7,  1'b1, 1'b0, 1'b1, 1'b0);
    do_op(16'h4321, 4'd9,  1'b1, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++)
      do_op(16'($urandom), 4'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'b0);

    // Reset two edges into an 8-step operation: abort with no done pulse.
    @(negedge clk);
    A = 16'h00FF; B = 4'd8; dir = 1'b0; s = 1'b0; rot = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("pre_abort_busy", busy, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_out", out, 16'h0000);
    chk("abort_co", co, 1'b0);
    chk("abort_busy", busy, 1'b0);
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      if (done) seen++;
      @(negedge clk);
    end
    chk("abort_no_done", seen, 0);
    do_op(16'h0F0F, 4'd6, 1'b1, 1'b1, 1'b1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
